// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents:
//   RESET_PC_DEFAULT : first fetch address after reset
//   fetch_state_t    : fetch FSM states (REQ, WAIT, HOLD)
//   D_fields_t       : instruction split into the fields decode consumes
//   split_instr      : helper that maps a raw instruction word onto D_fields_t
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [5:0] icode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    logic [5:0] acode;
  } D_fields_t;

  function automatic D_fields_t split_instr(input logic [31:0] instr);
    D_fields_t f;
    f.icode = instr[31:26];
    f.rs    = instr[25:21];
    f.rt    = instr[20:16];
    f.rd    = instr[15:11];
    f.sa    = instr[10:6];
    f.acode = instr[5:0];
    return f;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction bus between the fetch stage (master) and the memory side (slave).
// Signals:
//   ireq_valid    : request valid (master -> slave)
//   ireq_addr     : word-aligned request address (master -> slave)
//   iresp_addr_ok : address accepted this cycle (slave -> master)
//   iresp_data_ok : data returned this cycle (slave -> master)
//   iresp_data    : instruction word, valid with iresp_data_ok (slave -> master)
interface fetch_unit_if;

  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );

endinterface

// File: rtl/fetch_dreg.sv
// F->D pipeline register: holds the instruction fields and PC presented to decode.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears fields and PC)
//   stall_i    : decode stall; register holds its contents
//   load_i     : a fetched instruction is delivered this cycle
//   instr_i    : instruction word to load
//   pc_i       : PC of that instruction
//   fields_o   : registered instruction fields (all zero = SLL $0 nop)
//   pc_o       : registered PC of the instruction in D
module fetch_dreg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output D_fields_t   fields_o,
  output logic [31:0] pc_o
);

  D_fields_t   fields_p1;
  logic [31:0] dpc_p1;

  // ---- F -> D stage boundary ----
  // An unstalled cycle with nothing to load injects a nop; the PC is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      fields_p1 <= '0;
      dpc_p1    <= '0;
    end else if (!stall_i) begin
      if (load_i) begin
        fields_p1 <= split_instr(instr_i);
        dpc_p1    <= pc_i;
      end else begin
        fields_p1 <= '0;
      end
    end
  end

  assign fields_o = fields_p1;
  assign pc_o     = dpc_p1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, single-outstanding instruction bus
// requests, delay-slot-aware redirect, and the F->D register.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   ibus              : instruction bus (master side)
//   D_stall           : decode holds; D register must not change
//   d_jump, d_val2    : taken branch/jump in D and its target
//   D_pc, D_icode..D_acode : registered instruction in D and its PC
//   f_pc              : PC of the fetch in progress (delay slot)
//   pred_pc           : f_pc + 4 (JAL link value)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        ibus,
  input  logic                D_stall,
  input  logic                d_jump,
  input  logic [31:0]         d_val2,
  output logic [31:0]         D_pc,
  output logic [5:0]          D_icode,
  output logic [4:0]          D_rs,
  output logic [4:0]          D_rt,
  output logic [4:0]          D_rd,
  output logic [4:0]          D_sa,
  output logic [5:0]          D_acode,
  output logic [31:0]         f_pc,
  output logic [31:0]         pred_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  hold_q, hold_d;

  logic         redirect;
  logic         word_ret;
  logic         load;
  logic         use_hold;
  logic         advance;
  logic [31:0]  instr_sel;
  D_fields_t    dfields;

  assign redirect = d_jump && !D_stall;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    hold_d   = hold_q;
    word_ret = 1'b0;
    load     = 1'b0;
    use_hold = 1'b0;
    advance  = 1'b0;

    // A later jump simply overwrites the stored target.
    if (redirect) begin
      pend_d = 1'b1;
      tgt_d  = d_val2;
    end

    case (state_q)
      ST_REQ: begin
        if (ibus.iresp_addr_ok) begin
          // Data arriving with the address acceptance is the WAIT exit.
          if (ibus.iresp_data_ok) word_ret = 1'b1;
          else                    state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ibus.iresp_data_ok) word_ret = 1'b1;
      end
      ST_HOLD: begin
        if (!D_stall) begin
          load     = 1'b1;
          use_hold = 1'b1;
          advance  = 1'b1;
          state_d  = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (word_ret) begin
      if (!D_stall) begin
        load    = 1'b1;
        advance = 1'b1;
        state_d = ST_REQ;
      end else begin
        hold_d  = ibus.iresp_data;
        state_d = ST_HOLD;
      end
    end

    // The delay slot has just completed: a jump resolving in this very cycle
    // takes effect immediately, otherwise a pending target is consumed.
    if (advance) begin
      if (redirect)    pc_d = d_val2;
      else if (pend_q) pc_d = tgt_q;
      else             pc_d = pc_q + 32'd4;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    tgt_q  <= tgt_d;
    hold_q <= hold_d;
  end

  assign ibus.ireq_valid = (state_q == ST_REQ);
  assign ibus.ireq_addr  = {pc_q[31:2], 2'b00};
  assign f_pc            = pc_q;
  assign pred_pc         = pc_q + 32'd4;
  assign instr_sel       = use_hold ? hold_q : ibus.iresp_data;

  fetch_dreg u_dreg (
    .clk      (clk),
    .reset    (reset),
    .stall_i  (D_stall),
    .load_i   (load),
    .instr_i  (instr_sel),
    .pc_i     (pc_q),
    .fields_o (dfields),
    .pc_o     (D_pc)
  );

  assign D_icode = dfields.icode;
  assign D_rs    = dfields.rs;
  assign D_rt    = dfields.rt;
  assign D_rd    = dfields.rd;
  assign D_sa    = dfields.sa;
  assign D_acode = dfields.acode;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a small bus responder returns an address-derived word
// for every accepted request and pushes {addr, word} onto an expected queue;
// every new instruction appearing in D is captured onto an observed queue.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        D_stall;
  logic        d_jump;
  logic [31:0] d_val2;
  logic [31:0] D_pc;
  logic [5:0]  D_icode;
  logic [4:0]  D_rs, D_rt, D_rd, D_sa;
  logic [5:0]  D_acode;
  logic [31:0] f_pc, pred_pc;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk     (clk),
    .reset   (reset),
    .ibus    (bus),
    .D_stall (D_stall),
    .d_jump  (d_jump),
    .d_val2  (d_val2),
    .D_pc    (D_pc),
    .D_icode (D_icode),
    .D_rs    (D_rs),
    .D_rt    (D_rt),
    .D_rd    (D_rd),
    .D_sa    (D_sa),
    .D_acode (D_acode),
    .f_pc    (f_pc),
    .pred_pc (pred_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  int          aok_delay  = 0;
  int          dok_delay  = 0;
  bit          same_cycle = 1'b0;
  bit          inflight   = 1'b0;
  int          aok_cnt    = 0;
  int          dcnt       = 0;
  logic [31:0] fl_addr    = '0;
  logic [31:0] prev_word  = '0;
  logic [31:0] prev_pc    = '0;

  function automatic logic [31:0] word_for(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return {6'h0d, 5'd3, 5'd4, a[17:2]};
  endfunction

  function automatic logic [31:0] dword();
    return {D_icode, D_rs, D_rt, D_rd, D_sa, D_acode};
  endfunction

  // Decide bus responses for the coming clock edge from the current DUT request.
  task automatic drive_bus();
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = 32'hDEAD_BEEF;
    if (inflight) begin
      if (dcnt > 0) dcnt--;
      else begin
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = word_for(fl_addr);
        exp_q.push_back({fl_addr, word_for(fl_addr)});
        inflight = 1'b0;
      end
    end else if (bus.ireq_valid === 1'b1) begin
      if (aok_cnt < aok_delay) aok_cnt++;
      else begin
        aok_cnt           = 0;
        bus.iresp_addr_ok = 1'b1;
        fl_addr           = bus.ireq_addr;
        if (same_cycle) begin
          bus.iresp_data_ok = 1'b1;
          bus.iresp_data    = word_for(fl_addr);
          exp_q.push_back({fl_addr, word_for(fl_addr)});
        end else begin
          inflight = 1'b1;
          dcnt     = dok_delay;
        end
      end
    end
  endtask

  task automatic tick();
    logic [31:0] cur;
    drive_bus();
    @(posedge clk);
    #1;
    cur = dword();
    if (cur != 32'd0 && (prev_word == 32'd0 || D_pc != prev_pc))
      obs_q.push_back({D_pc, cur});
    prev_word = cur;
    prev_pc   = D_pc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset     = 1'b0;
    exp_q.delete();
    obs_q.delete();
    inflight  = 1'b0;
    aok_cnt   = 0;
    prev_word = '0;
    prev_pc   = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.ireq_valid !== 1'b1) begin bad++; $display("FAIL rst_valid got=%b want=1", bus.ireq_valid); end
    total++; if (bus.ireq_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL rst_addr got=%h want=bfc00000", bus.ireq_addr); end
    total++; if (dword() !== 32'd0) begin bad++; $display("FAIL rst_fields got=%h want=0", dword()); end
    total++; if (D_pc !== 32'd0) begin bad++; $display("FAIL rst_dpc got=%h want=0", D_pc); end
    total++; if (f_pc !== 32'hBFC0_0000) begin bad++; $display("FAIL rst_fpc got=%h want=bfc00000", f_pc); end
    total++; if (pred_pc !== 32'hBFC0_0004) begin bad++; $display("FAIL rst_predpc got=%h want=bfc00004", pred_pc); end
    total++; if (dut.pend_q !== 1'b0) begin bad++; $display("FAIL rst_pend got=%b want=0", dut.pend_q); end
  endtask

  task automatic test_basic();
    logic [63:0] e, o;
    do_reset();
    tick();
    total++; if (bus.ireq_valid !== 1'b0) begin bad++; $display("FAIL basic_wait_valid got=%b want=0", bus.ireq_valid); end
    total++; if (dword() !== 32'd0) begin bad++; $display("FAIL basic_wait_bubble got=%h want=0", dword()); end
    tick();
    total++; if (D_icode !== 6'h09) begin bad++; $display("FAIL basic_icode got=%h want=09", D_icode); end
    total++; if (D_rt !== 5'd2) begin bad++; $display("FAIL basic_rt got=%h want=02", D_rt); end
    total++; if (D_rs !== 5'd0 || D_acode !== 6'd5) begin bad++; $display("FAIL basic_rs_acode got=%h/%h want=00/05", D_rs, D_acode); end
    total++; if (D_pc !== 32'hBFC0_0000) begin bad++; $display("FAIL basic_dpc got=%h want=bfc00000", D_pc); end
    total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hBFC0_0004) begin bad++; $display("FAIL basic_next_req got=%b/%h want=1/bfc00004", bus.ireq_valid, bus.ireq_addr); end
    tick();
    total++; if (dword() !== 32'd0 || D_pc !== 32'hBFC0_0000) begin bad++; $display("FAIL basic_bubble got=%h/%h want=0/bfc00000", dword(), D_pc); end
    tick();
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL basic_sb got=%h want=%h", o, e); end
    end
    total++; if (exp_q.size() != obs_q.size()) begin bad++; $display("FAIL basic_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    same_cycle = 1'b1;
    repeat (4) tick();
    same_cycle = 1'b0;
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL b2b_rate got=%0d want=4", obs_q.size()); end
    total++; if (D_pc !== 32'hBFC0_0014 || bus.ireq_addr !== 32'hBFC0_0018) begin bad++; $display("FAIL b2b_pc got=%h/%h want=bfc00014/bfc00018", D_pc, bus.ireq_addr); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL b2b_sb got=%h want=%h", o, e); end
    end
    total++; if (exp_q.size() != obs_q.size()) begin bad++; $display("FAIL b2b_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_stall();
    logic [63:0] e, o;
    do_reset();
    tick();
    tick();
    D_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dword() !== 32'h2402_0005 || D_pc !== 32'hBFC0_0000) begin bad++; $display("FAIL stall_hold%0d got=%h/%h want=24020005/bfc00000", i, dword(), D_pc); end
      total++; if (bus.ireq_valid !== 1'b0) begin bad++; $display("FAIL stall_noreq%0d got=%b want=0", i, bus.ireq_valid); end
      if (i > 0) begin
        total++; if (dut.state_q !== ST_HOLD) begin bad++; $display("FAIL stall_state%0d got=%0d want=%0d", i, dut.state_q, ST_HOLD); end
      end
    end
    D_stall = 1'b0;
    tick();
    total++; if (D_pc !== 32'hBFC0_0004) begin bad++; $display("FAIL stall_release_dpc got=%h want=bfc00004", D_pc); end
    total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hBFC0_0008) begin bad++; $display("FAIL stall_release_req got=%b/%h want=1/bfc00008", bus.ireq_valid, bus.ireq_addr); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL stall_sb got=%h want=%h", o, e); end
    end
    total++; if (exp_q.size() != obs_q.size()) begin bad++; $display("FAIL stall_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_redirect();
    logic [63:0] e, o;
    do_reset();
    dok_delay = 2;
    for (int i = 0; i < 40; i++) begin
      if (bus.ireq_valid === 1'b0 && bus.ireq_addr === 32'hBFC0_0008) break;
      tick();
    end
    total++; if (!(bus.ireq_valid === 1'b0 && bus.ireq_addr === 32'hBFC0_0008)) begin bad++; $display("FAIL redir_reach_wait got=%b/%h want=0/bfc00008", bus.ireq_valid, bus.ireq_addr); end
    d_jump = 1'b1; d_val2 = 32'hBFC0_0200;
    tick();
    d_val2 = 32'hBFC0_0100;
    tick();
    d_jump = 1'b0;
    total++; if (dut.pend_q !== 1'b1) begin bad++; $display("FAIL redir_pend_set got=%b want=1", dut.pend_q); end
    for (int i = 0; i < 20; i++) begin
      if (D_pc === 32'hBFC0_0008) break;
      tick();
    end
    total++; if (D_pc !== 32'hBFC0_0008) begin bad++; $display("FAIL redir_slot_dpc got=%h want=bfc00008", D_pc); end
    total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hBFC0_0100) begin bad++; $display("FAIL redir_target got=%b/%h want=1/bfc00100", bus.ireq_valid, bus.ireq_addr); end
    total++; if (dut.pend_q !== 1'b0) begin bad++; $display("FAIL redir_pend_clr got=%b want=0", dut.pend_q); end
    dok_delay = 0;
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL redir_sb got=%h want=%h", o, e); end
    end
    total++; if (exp_q.size() != obs_q.size()) begin bad++; $display("FAIL redir_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_addr_delay();
    logic [63:0] e, o;
    do_reset();
    tick();
    tick();
    aok_delay = 4;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hBFC0_0004) begin bad++; $display("FAIL adly_req%0d got=%b/%h want=1/bfc00004", i, bus.ireq_valid, bus.ireq_addr); end
      total++; if (dword() !== 32'd0 || D_pc !== 32'hBFC0_0000) begin bad++; $display("FAIL adly_bubble%0d got=%h/%h want=0/bfc00000", i, dword(), D_pc); end
    end
    tick();
    tick();
    aok_delay = 0;
    total++; if (D_pc !== 32'hBFC0_0004) begin bad++; $display("FAIL adly_dpc got=%h want=bfc00004", D_pc); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL adly_sb got=%h want=%h", o, e); end
    end
    total++; if (exp_q.size() != obs_q.size()) begin bad++; $display("FAIL adly_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    tick();
    D_stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    total++; if (dword() !== 32'd0 || D_pc !== 32'd0) begin bad++; $display("FAIL rmid_dreg got=%h/%h want=0/0", dword(), D_pc); end
    total++; if (f_pc !== 32'hBFC0_0000) begin bad++; $display("FAIL rmid_pc got=%h want=bfc00000", f_pc); end
    total++; if (dut.state_q !== ST_REQ || bus.ireq_valid !== 1'b1) begin bad++; $display("FAIL rmid_state got=%0d/%b want=%0d/1", dut.state_q, bus.ireq_valid, ST_REQ); end
    reset   = 1'b0;
    D_stall = 1'b0;
    exp_q.delete();
    obs_q.delete();
    inflight  = 1'b0;
    aok_cnt   = 0;
    prev_word = '0;
    prev_pc   = '0;
  endtask

  task automatic test_wrap();
    logic [63:0] e, o;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (bus.ireq_valid === 1'b0 && bus.ireq_addr === 32'hBFC0_0004) break;
      tick();
    end
    total++; if (!(bus.ireq_valid === 1'b0 && bus.ireq_addr === 32'hBFC0_0004)) begin bad++; $display("FAIL wrap_reach_wait got=%b/%h want=0/bfc00004", bus.ireq_valid, bus.ireq_addr); end
    d_jump = 1'b1; d_val2 = 32'hFFFF_FFFC;
    tick();
    d_jump = 1'b0;
    total++; if (D_pc !== 32'hBFC0_0004) begin bad++; $display("FAIL wrap_slot_dpc got=%h want=bfc00004", D_pc); end
    total++; if (f_pc !== 32'hFFFF_FFFC || bus.ireq_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fpc got=%h/%h want=fffffffc/fffffffc", f_pc, bus.ireq_addr); end
    total++; if (pred_pc !== 32'd0) begin bad++; $display("FAIL wrap_predpc got=%h want=0", pred_pc); end
    total++; if (dut.pend_q !== 1'b0) begin bad++; $display("FAIL wrap_pend got=%b want=0", dut.pend_q); end
    tick();
    tick();
    total++; if (D_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_dpc got=%h want=fffffffc", D_pc); end
    total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'd0) begin bad++; $display("FAIL wrap_next_req got=%b/%h want=1/0", bus.ireq_valid, bus.ireq_addr); end
    total++; if (pred_pc !== 32'd4) begin bad++; $display("FAIL wrap_predpc0 got=%h want=4", pred_pc); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wrap_sb got=%h want=%h", o, e); end
    end
    total++; if (exp_q.size() != obs_q.size()) begin bad++; $display("FAIL wrap_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
  endtask

  initial begin
    reset             = 1'b1;
    D_stall           = 1'b0;
    d_jump            = 1'b0;
    d_val2            = '0;
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = '0;

    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_addr_delay();
    test_reset_mid();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
